// File: rtl/dispatch_queue_if.sv
// Dispatch queue signal bundle: ID enqueue side, regfile/ROB operand lookup,
// CDB snoop channels and the issue side towards RS/LSB.
interface dispatch_queue_if #(
    parameter int unsigned N_CDB  = 2,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned DATA_W = 32
);
    logic                      flush_in;

    logic                      in_valid;
    logic                      in_ready;
    logic [5:0]                in_op;
    logic [DATA_W-1:0]         in_a;
    logic [4:0]                in_rd;
    logic [DATA_W-1:0]         in_pc;
    logic [1:0]                in_ctl;
    logic [1:0]                in_use;

    logic [1:0]                src_busy;
    logic [2*DATA_W-1:0]       src_val;
    logic [1:0]                rob_src_ready;
    logic [2*DATA_W-1:0]       rob_src_val;
    logic                      rob_full;
    logic [ROB_W-1:0]          rob_nxtpos;
    logic                      rob_alloc;
    logic                      reg_rename;

    logic [N_CDB-1:0]          cdb_valid;
    logic [N_CDB*ROB_W-1:0]    cdb_tag;
    logic [N_CDB*DATA_W-1:0]   cdb_val;

    logic                      rs_full;
    logic                      lsb_full;
    logic [1:0]                out_valid;
    logic [5:0]                out_op;
    logic [DATA_W-1:0]         out_a;
    logic [4:0]                out_rd;
    logic [DATA_W-1:0]         out_pc;
    logic [ROB_W-1:0]          out_tag;
    logic [1:0]                out_q;
    logic [2*DATA_W-1:0]       out_v;

    // Environment side: ID, regfile, ROB, CDB and the issue targets.
    modport master (
        output flush_in, in_valid, in_op, in_a, in_rd, in_pc, in_ctl, in_use,
        output src_busy, src_val, rob_src_ready, rob_src_val, rob_full, rob_nxtpos,
        output cdb_valid, cdb_tag, cdb_val, rs_full, lsb_full,
        input  in_ready, rob_alloc, reg_rename,
        input  out_valid, out_op, out_a, out_rd, out_pc, out_tag, out_q, out_v
    );

    // Queue side.
    modport slave (
        input  flush_in, in_valid, in_op, in_a, in_rd, in_pc, in_ctl, in_use,
        input  src_busy, src_val, rob_src_ready, rob_src_val, rob_full, rob_nxtpos,
        input  cdb_valid, cdb_tag, cdb_val, rs_full, lsb_full,
        output in_ready, rob_alloc, reg_rename,
        output out_valid, out_op, out_a, out_rd, out_pc, out_tag, out_q, out_v
    );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: allocates a ROB tag and renames rd at enqueue,
// resolves operands from regfile/ROB/CDB, snoops the CDB while queued and
// issues the head to RS or LSB as a registered one-cycle pulse.
module dispatch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned N_CDB  = 2,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    dispatch_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pending operands keep their tag zero-extended in v, so an entry maps
    // directly onto the issue payload.
    typedef struct packed {
        logic [5:0]             op;
        logic [DATA_W-1:0]      a;
        logic [4:0]             rd;
        logic [DATA_W-1:0]      pc;
        logic [ROB_W-1:0]       tag;
        logic                   cls;
        logic [1:0]             q;
        logic [1:0][DATA_W-1:0] v;
    } entry_t;

    entry_t           ent_q     [DEPTH];
    entry_t           ent_snoop [DEPTH];
    entry_t           ent_d     [DEPTH];
    entry_t           new_ent;
    entry_t           head_ent;
    entry_t           out_ent_q;
    logic             out_pulse_q;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;

    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*ROB_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_val;

    assign cdb_valid = bus.cdb_valid;
    assign cdb_tag   = bus.cdb_tag;
    assign cdb_val   = bus.cdb_val;

    // Returns {hit, value}; the lowest matching channel wins.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int unsigned c = 0; c < N_CDB; c++) begin
            if (!res[DATA_W] && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, cdb_val[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Handshake: no pass-through when full, nothing accepted during flush.
    assign bus.in_ready   = (count_q < FULL_CNT) && !bus.rob_full && !bus.flush_in;
    assign push           = bus.in_valid && bus.in_ready;
    assign bus.rob_alloc  = push;
    assign bus.reg_rename = push && bus.in_ctl[1];

    // Build the incoming entry, resolving each operand in priority order.
    always_comb begin : build_new
        logic [DATA_W-1:0] sv;
        logic [DATA_W:0]   hit;
        new_ent     = '0;
        new_ent.op  = bus.in_op;
        new_ent.a   = bus.in_a;
        new_ent.rd  = bus.in_rd;
        new_ent.pc  = bus.in_pc;
        new_ent.tag = bus.rob_nxtpos;
        new_ent.cls = bus.in_ctl[0];
        for (int unsigned i = 0; i < 2; i++) begin
            sv  = bus.src_val[i*DATA_W +: DATA_W];
            hit = '0;
            if (!bus.in_use[i]) begin
                new_ent.v[i] = '0;
            end else if (!bus.src_busy[i]) begin
                new_ent.v[i] = sv;
            end else if (bus.rob_src_ready[i]) begin
                new_ent.v[i] = bus.rob_src_val[i*DATA_W +: DATA_W];
            end else begin
                hit = cdb_lookup(sv[ROB_W-1:0]);
                if (hit[DATA_W]) begin
                    new_ent.v[i] = hit[DATA_W-1:0];
                end else begin
                    new_ent.q[i] = 1'b1;
                    new_ent.v[i] = DATA_W'(sv[ROB_W-1:0]);
                end
            end
        end
    end

    // Wake up pending operands of every entry from this cycle's broadcasts.
    always_comb begin : snoop
        logic [DATA_W:0] hit;
        hit = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            ent_snoop[e] = ent_q[e];
            for (int unsigned i = 0; i < 2; i++) begin
                if (ent_q[e].q[i]) begin
                    hit = cdb_lookup(ent_q[e].v[i][ROB_W-1:0]);
                    if (hit[DATA_W]) begin
                        ent_snoop[e].q[i] = 1'b0;
                        ent_snoop[e].v[i] = hit[DATA_W-1:0];
                    end
                end
            end
        end
    end

    // Head issues when its target unit has room; snooped copy feeds the payload.
    assign head_ent = ent_snoop[head_q];
    assign pop      = (count_q != '0) && !bus.flush_in &&
                      (head_ent.cls ? !bus.lsb_full : !bus.rs_full);

    // Next-state storage and occupancy.
    always_comb begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            ent_d[e] = ent_snoop[e];
        end
        if (push) begin
            ent_d[tail_q] = new_ent;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                ent_q[e] <= '0;
            end
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                ent_q[e] <= ent_d[e];
            end
        end
    end

    // Pointers and count; flush empties the queue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Issue register: one-cycle pulse, payload held until the next issue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_pulse_q <= 1'b0;
            out_ent_q   <= '0;
        end else if (bus.flush_in) begin
            out_pulse_q <= 1'b0;
            out_ent_q   <= '0;
        end else begin
            out_pulse_q <= pop;
            if (pop) begin
                out_ent_q <= head_ent;
            end
        end
    end

    assign bus.out_valid = {out_pulse_q && out_ent_q.cls, out_pulse_q && !out_ent_q.cls};
    assign bus.out_op    = out_ent_q.op;
    assign bus.out_a     = out_ent_q.a;
    assign bus.out_rd    = out_ent_q.rd;
    assign bus.out_pc    = out_ent_q.pc;
    assign bus.out_tag   = out_ent_q.tag;
    assign bus.out_q     = out_ent_q.q;
    assign bus.out_v     = out_ent_q.v;
endmodule
